// File: rtl/digit_shift_entry.sv
// Digit-entry shift register: edge-detected pushes shift digits in at the LSB end.
// Define DIGIT_SHIFT_BKSP_EN to build the backspace (pop) path on bksp.
module digit_shift_entry #(
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned DEPTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bttn,
  input  logic                     bksp,
  input  logic                     clr,
  input  logic [DIGIT_W-1:0]       bit_in,
  output logic [DIGIT_W*DEPTH-1:0] dato,
  output logic [CW-1:0]            count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  logic [DIGIT_W*DEPTH-1:0] dato_q, dato_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     bttn_q;
  logic                     push_evt;

`ifdef DIGIT_SHIFT_BKSP_EN
  logic bksp_q;
  logic pop_evt;
  assign pop_evt = bksp & ~bksp_q;
`else
  logic unused_bksp;
  assign unused_bksp = bksp;
`endif

  assign push_evt = bttn & ~bttn_q;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign dato     = dato_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    dato_d     = dato_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (clr) begin
      dato_d  = '0;
      count_d = '0;
    end else if (push_evt) begin
      if (full) begin
        overflow_d = 1'b1;
        // Non-saturating: the oldest digit falls off the top, count stays at DEPTH.
        if (!SATURATE) begin
          dato_d = {dato_q[DIGIT_W*(DEPTH-1)-1:0], bit_in};
        end
      end else begin
        dato_d  = {dato_q[DIGIT_W*(DEPTH-1)-1:0], bit_in};
        count_d = count_q + CW'(1);
      end
    end
`ifdef DIGIT_SHIFT_BKSP_EN
    else if (pop_evt && !empty) begin
      dato_d  = {{DIGIT_W{1'b0}}, dato_q[DIGIT_W*DEPTH-1:DIGIT_W]};
      count_d = count_q - CW'(1);
    end
`endif
  end

  // Edge registers preset to 1 so a button held through reset yields no event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dato_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bttn_q     <= 1'b1;
`ifdef DIGIT_SHIFT_BKSP_EN
      bksp_q     <= 1'b1;
`endif
    end else begin
      dato_q     <= dato_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bttn_q     <= bttn;
`ifdef DIGIT_SHIFT_BKSP_EN
      bksp_q     <= bksp;
`endif
    end
  end

endmodule

// File: doc/digit_shift_entry.md
# digit_shift_entry

Parametrised digit-entry shift register for the keypad/switch-to-display path. Each debounced button press shifts a DIGIT_W-bit value in at the least-significant digit and pushes older digits toward the most-significant end. The block tracks how many digits are valid, flags full/empty, reports overflow, and optionally supports backspace. Its packed output feeds the multi-digit display driver and the downstream operand registers directly.

## Interface
- DIGIT_W, default 4: bits per digit.
- DEPTH, default 4: number of digits held; legal values are 2 to 16.
- SATURATE, default 0: full-buffer policy. 0 discards the oldest digit on push; 1 ignores the push.
- CW, default $clog2(DEPTH+1): width of count. Derived; never overridden.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- bttn  in  1  push request, level, already debounced upstream; edge-detected internally.
- bksp  in  1  backspace request, level, debounced; edge-detected internally.
- clr  in  1  synchronous clear, active-high level.
- bit_in  in  DIGIT_W  digit value captured on a push event.
- dato  out  DIGIT_W*DEPTH  packed digits. Digit 0 at [DIGIT_W-1:0] is the newest.
- count  out  CW  number of valid digits, 0..DEPTH.
- full  out  1  high when count == DEPTH.
- empty  out  1  high when count == 0.
- overflow  out  1  one-cycle pulse when a push arrives while full.

## Operation
- Edge detectors hold registered copies bttn_q and bksp_q.
  - push_evt = bttn & ~bttn_q.
  - pop_evt = bksp & ~bksp_q.
  - A held button yields exactly one event.
- Priority, highest first: rst low, clr, push_evt, pop_evt. Only one action occurs per cycle. A push_evt and pop_evt in the same cycle performs the push only.
- rst low:
  - dato = 0, count = 0, overflow = 0.
  - bttn_q = 1 and bksp_q = 1, so a button held through reset produces no event.
- clr high:
  - dato = 0, count = 0, overflow = 0.
  - Edge registers keep tracking their inputs, so a press overlapping clr produces no event after clr drops.
- push_evt, not full:
  - dato = {dato[DIGIT_W*(DEPTH-1)-1:0], bit_in}.
  - count + 1.
- push_evt, full, SATURATE=0:
  - Same shift; the top digit is discarded.
  - count stays DEPTH; overflow = 1.
- push_evt, full, SATURATE=1:
  - dato unchanged, count unchanged; overflow = 1.
- pop_evt, not empty (backspace compiled in):
  - dato = {DIGIT_W'b0, dato[DIGIT_W*DEPTH-1:DIGIT_W]}.
  - count - 1.
- pop_evt, empty: no change.
- Digits above count are always zero. Every path that lowers count shifts zeros in, so this holds without extra logic.
- full and empty are combinational decodes of registered count.
- overflow is registered. It is cleared on every cycle that does not raise it.

## Timing
- Latency of one clock: an input rising edge sampled at clk edge N updates dato, count, full, empty and overflow after edge N.
- The minimum spacing between events on the same input is 2 cycles (low for ≥1 sampled cycle). Faster toggling is a caller error.
- rst low or clr high at edge N overrides any event sampled at edge N.
- All outputs read 0 after reset, except empty = 1.

## Configuration
- DIGIT_SHIFT_BKSP_EN defined:
  - The bksp edge detector and pop path are built as described.
- DIGIT_SHIFT_BKSP_EN undefined:
  - bksp stays in the port list but is ignored.
  - bksp_q and the pop datapath are not synthesised.
  - dato and count change only via rst, clr and push_evt.

## Test plan
- Reset with bttn held high, then release and press with bit_in=4'h3 (DIGIT_W=4, DEPTH=4) → no event during hold; after the press, dato=16'h0003, count=1, empty=0.
- Four presses with 1, 2, 3, 4 → dato=16'h1234, full=1. A fifth press with 5 under SATURATE=0 → dato=16'h2345, overflow high exactly 1 cycle. Under SATURATE=1 → dato stays 16'h1234, overflow pulses.
- Hold bttn high for 20 cycles with bit_in=4'h7 from empty → exactly one shift, dato=16'h0007, count=1.
- With DIGIT_SHIFT_BKSP_EN and dato=16'h1234, two bksp presses → 16'h0123, then 16'h0012, count=2. From empty, a bksp press → no change. With the macro undefined → no change in either case.
- bttn and bksp rising in the same cycle with bit_in=4'h9 from 16'h0012 → dato=16'h0129, count=3.
- clr high coincident with a push event at dato=16'h0129 → dato=0, count=0, overflow=0. rst low mid-entry → same values; the edge registers are set to 1.
